regfile_mp: RTL

//  Parametrised multi-port MIPS register file: NUM_RD async read ports, NUM_WR write ports

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_mp.sv | 62 ++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing helper, zero-register index and register typedefs for regfile_mp.
package regfile_pkg;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int ZERO_REG = 0;
  typedef logic [addr_w(32)-1:0] reg_addr_t;
  typedef logic [31:0] reg_data_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bus into the register file (writes, reads, reservations).
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
);
  localparam int ADDR_W = addr_w(NUM_REGS);
  logic [NUM_WR-1:0]        wrEn;
  logic [NUM_WR*ADDR_W-1:0] wrAddr;
  logic [NUM_WR*DATA_W-1:0] wrData;
  logic [NUM_RD*ADDR_W-1:0] rdAddr;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]        rdBusy;
  logic                     rsvEn;
  logic [ADDR_W-1:0]        rsvAddr;
  logic [ADDR_W:0]          numPending;
  modport master (
    output wrEn, wrAddr, wrData, rdAddr, rsvEn, rsvAddr,
    input  rdData, rdBusy, numPending
  );
  modport slave (
    input  wrEn, wrAddr, wrData, rdAddr, rsvEn, rsvAddr,
    output rdData, rdBusy, numPending
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bits per register, registered pending count and per-read busy lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD-1:0]        rd_mask_i,
  output logic [NUM_RD-1:0]        rd_busy_o,
  output logic [ADDR_W:0]          num_pending_o
);
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     num_q, num_d;
  // reserve is applied after the clears so a newer producer keeps the register pending
  always_comb begin
    pend_d = pend_q;
    num_d  = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_en_i[p]) pend_d[wr_addr_i[p*ADDR_W +: ADDR_W]] = 1'b0;
    if (rsv_en_i) pend_d[rsv_addr_i] = 1'b1;
    pend_d[ZERO_REG] = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      num_d = num_d + {{ADDR_W{1'b0}}, pend_d[r]};
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      pend_q <= '0;
      num_q  <= '0;
    end else begin
      pend_q <= pend_d;
      num_q  <= num_d;
    end
  end
  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_busy_o[i] = pend_q[rd_addr_i[i*ADDR_W +: ADDR_W]] & ~rd_mask_i[i];
  end
  assign num_pending_o = num_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with r0 hardwired to zero, optional write-to-read bypass
// and a pending-write scoreboard for RAW hazard stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         resetN,
  regfile_mp_if.slave  bus
);
  localparam int ADDR_W = addr_w(NUM_REGS);
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [NUM_RD-1:0] rd_hit;
  // ascending port order makes the highest-numbered port win on an address clash
  always_comb begin
    rf_d = rf_q;
    for (int p = 0; p < NUM_WR; p++)
      if (bus.wrEn[p]) rf_d[bus.wrAddr[p*ADDR_W +: ADDR_W]] = bus.wrData[p*DATA_W +: DATA_W];
    rf_d[ZERO_REG] = '0;
  end
  always_ff @(posedge clk) begin
    if (!resetN) rf_q <= '{default: '0};
    else         rf_q <= rf_d;
  end
  always_comb begin
    rd_hit      = '0;
    bus.rdData  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rdData[i*DATA_W +: DATA_W] = rf_q[bus.rdAddr[i*ADDR_W +: ADDR_W]];
      for (int p = 0; p < NUM_WR; p++)
        if (BYPASS != 0 && bus.wrEn[p] && bus.wrAddr[p*ADDR_W +: ADDR_W] == bus.rdAddr[i*ADDR_W +: ADDR_W]) begin
          rd_hit[i]                      = 1'b1;
          bus.rdData[i*DATA_W +: DATA_W] = bus.wrData[p*DATA_W +: DATA_W];
        end
      if (bus.rdAddr[i*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_REG))
        bus.rdData[i*DATA_W +: DATA_W] = '0;
    end
  end
  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk           (clk),
    .resetN        (resetN),
    .wr_en_i       (bus.wrEn),
    .wr_addr_i     (bus.wrAddr),
    .rsv_en_i      (bus.rsvEn),
    .rsv_addr_i    (bus.rsvAddr),
    .rd_addr_i     (bus.rdAddr),
    .rd_mask_i     (rd_hit),
    .rd_busy_o     (bus.rdBusy),
    .num_pending_o (bus.numPending)
  );
endmodule
